// File: rtl/multicycle_control_if.sv
// Control interface between the multi-cycle main controller and the MIPS
// datapath/memory.
//   master : controller side. It receives opcode, mem_ready and n_flag, and
//            drives every control strobe/select plus state, instr_done and
//            illegal_op.
//   slave  : datapath side. It drives the status inputs and receives the
//            control word.
interface multicycle_control_if;
  logic [5:0] opcode;      // IR[31:26]
  logic       mem_ready;   // memory completes current access this cycle
  logic       n_flag;      // negative status flag (baln)

  logic       pcwrite, pcwritecond, iord, irwrite, memread, memwrite;
  logic       regwrite, alusrca, zeroext;
  logic [1:0] alusrcb;     // 00 B, 01 4, 10 ext imm, 11 sext imm<<2
  logic [1:0] aluop;       // 00 add, 01 sub, 10 funct, 11 or
  logic [1:0] pcsource;    // 00 ALU, 01 ALUOut, 10 rs
  logic [1:0] regdest;     // 00 rt, 01 rd, 10 $31
  logic [1:0] memtoreg;    // 00 ALUOut, 01 MDR, 10 PC
  logic [3:0] state;       // debug view of the FSM state
  logic       instr_done;  // final cycle of an instruction
  logic       illegal_op;  // DECODE saw an unsupported opcode

  modport master (
    input  opcode, mem_ready, n_flag,
    output pcwrite, pcwritecond, iord, irwrite, memread, memwrite,
           regwrite, alusrca, zeroext, alusrcb, aluop, pcsource,
           regdest, memtoreg, state, instr_done, illegal_op
  );

  modport slave (
    output opcode, mem_ready, n_flag,
    input  pcwrite, pcwritecond, iord, irwrite, memread, memwrite,
           regwrite, alusrca, zeroext, alusrcb, aluop, pcsource,
           regdest, memtoreg, state, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller. Sequences fetch, decode, execute, memory
// and write-back for lw, sw, R-type, beq, ori, jrsal and baln on a shared
// ALU / unified memory / register file datapath.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; forces every output to 0 while high
//   bus   - multicycle_control_if.master (opcode/mem_ready/n_flag in,
//           control word, state, instr_done, illegal_op out)
// Outputs are Moore from the state, except the mem_ready-qualified strobes
// in FETCH/MEMWR and the n_flag-qualified writes in BALN.
module multicycle_control (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_if.master        bus
);

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_JRSAL = 6'b010001;
  localparam logic [5:0] OP_BALN  = 6'b011001;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_ORIEX  = 4'd9,
    S_ORIWB  = 4'd10,
    S_JRSAL  = 4'd11,
    S_BALN   = 4'd12
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d          = S_FETCH;
    bus.pcwrite      = 1'b0;
    bus.pcwritecond  = 1'b0;
    bus.iord         = 1'b0;
    bus.irwrite      = 1'b0;
    bus.memread      = 1'b0;
    bus.memwrite     = 1'b0;
    bus.regwrite     = 1'b0;
    bus.alusrca      = 1'b0;
    bus.zeroext      = 1'b0;
    bus.alusrcb      = 2'b00;
    bus.aluop        = 2'b00;
    bus.pcsource     = 2'b00;
    bus.regdest      = 2'b00;
    bus.memtoreg     = 2'b00;
    bus.instr_done   = 1'b0;
    bus.illegal_op   = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC+4 computed every cycle; only committed once the IR loads.
        bus.memread = 1'b1;
        bus.alusrcb = 2'b01;
        if (bus.mem_ready) begin
          bus.irwrite = 1'b1;
          bus.pcwrite = 1'b1;
          state_d     = S_DECODE;
        end else begin
          state_d     = S_FETCH;
        end
      end
      S_DECODE: begin
        // Speculative branch target PC + (sext imm << 2) into ALUOut.
        bus.alusrcb = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_REXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_ORI:       state_d = S_ORIEX;
          OP_JRSAL:     state_d = S_JRSAL;
          OP_BALN:      state_d = S_BALN;
          default: begin
            bus.illegal_op = 1'b1;
            state_d        = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        if      (bus.opcode == OP_LW) state_d = S_MEMRD;
        else if (bus.opcode == OP_SW) state_d = S_MEMWR;
        else                          state_d = S_FETCH;
      end
      S_MEMRD: begin
        bus.memread = 1'b1;
        bus.iord    = 1'b1;
        state_d     = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        bus.regwrite   = 1'b1;
        bus.memtoreg   = 2'b01;
        bus.instr_done = 1'b1;
      end
      S_MEMWR: begin
        bus.memwrite = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready) begin
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end else begin
          state_d        = S_MEMWR;
        end
      end
      S_REXEC: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b10;
        state_d     = S_RWB;
      end
      S_RWB: begin
        bus.regwrite   = 1'b1;
        bus.regdest    = 2'b01;
        bus.instr_done = 1'b1;
      end
      S_BEQ: begin
        bus.alusrca     = 1'b1;
        bus.aluop       = 2'b01;
        bus.pcwritecond = 1'b1;
        bus.pcsource    = 2'b01;
        bus.instr_done  = 1'b1;
      end
      S_ORIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        bus.zeroext = 1'b1;
        bus.aluop   = 2'b11;
        state_d     = S_ORIWB;
      end
      S_ORIWB: begin
        bus.regwrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_JRSAL: begin
        // PC still holds PC+4 this cycle, so $31 gets the return address
        // while the PC is redirected to rs.
        bus.pcwrite    = 1'b1;
        bus.pcsource   = 2'b10;
        bus.regwrite   = 1'b1;
        bus.regdest    = 2'b10;
        bus.memtoreg   = 2'b10;
        bus.instr_done = 1'b1;
      end
      S_BALN: begin
        if (bus.n_flag) begin
          bus.pcwrite  = 1'b1;
          bus.pcsource = 2'b01;
          bus.regwrite = 1'b1;
          bus.regdest  = 2'b10;
          bus.memtoreg = 2'b10;
        end
        bus.instr_done = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset abandons any instruction in flight: no strobe may fire.
    if (reset) begin
      bus.pcwrite     = 1'b0;
      bus.pcwritecond = 1'b0;
      bus.iord        = 1'b0;
      bus.irwrite     = 1'b0;
      bus.memread     = 1'b0;
      bus.memwrite    = 1'b0;
      bus.regwrite    = 1'b0;
      bus.alusrca     = 1'b0;
      bus.zeroext     = 1'b0;
      bus.alusrcb     = 2'b00;
      bus.aluop       = 2'b00;
      bus.pcsource    = 2'b00;
      bus.regdest     = 2'b00;
      bus.memtoreg    = 2'b00;
      bus.instr_done  = 1'b0;
      bus.illegal_op  = 1'b0;
    end
  end

  assign bus.state = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Each instruction is expanded into
// its expected per-cycle control words (including stall cycles) from the
// instruction-level rules; a single compare process checks every cycle.
// Hand-computed latencies and pulse totals pin the model.
module tb_multicycle_control;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_JRSAL = 6'b010001;
  localparam logic [5:0] OP_BALN  = 6'b011001;

  typedef struct packed {
    logic       pcwrite, pcwritecond, iord, irwrite, memread, memwrite;
    logic       regwrite, alusrca, zeroext;
    logic [1:0] alusrcb, aluop, pcsource, regdest, memtoreg;
    logic [3:0] state;
    logic       instr_done, illegal_op;
  } cw_t;

  typedef struct {
    logic       rst, rdy, nf;
    logic [5:0] op;
    cw_t        exp;
    int         lat;   // hand latency on the done cycle, else 0
  } cyc_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if bus();
  multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

  cyc_t stim_q[$];
  cyc_t exp_q[$];
  int total = 0, bad = 0;
  int done_cnt = 0, ill_cnt = 0, mw_cnt = 0, lat_cnt = 0, cyc = 0;

  function automatic cw_t st(int s);
    cw_t c = '0;
    c.state = 4'(s);
    return c;
  endfunction

  task automatic push(logic rst, logic rdy, logic nf, logic [5:0] op, cw_t e, int lat);
    cyc_t c;
    c.rst = rst; c.rdy = rdy; c.nf = nf; c.op = op; c.exp = e; c.lat = lat;
    stim_q.push_back(c);
  endtask

  task automatic do_fetch(logic [5:0] op, int stalls);
    cw_t c = st(0);
    c.memread = 1'b1; c.alusrcb = 2'b01;
    repeat (stalls) push(0, 0, 0, op, c, 0);
    c.irwrite = 1'b1; c.pcwrite = 1'b1;
    push(0, 1, 0, op, c, 0);
  endtask

  // One whole instruction: fstall/mstall are mem_ready=0 cycles in fetch
  // and the data-memory state; lat is the hand-computed total cycle count.
  task automatic run(logic [5:0] op, int fstall, int mstall, logic nf, int lat);
    cw_t c;
    bit legal;
    legal = op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ORI, OP_JRSAL, OP_BALN};
    do_fetch(op, fstall);
    c = st(1); c.alusrcb = 2'b11; c.illegal_op = !legal;
    push(0, 0, 0, op, c, 0);
    if (!legal) return;
    case (op)
      OP_LW, OP_SW: begin
        c = st(2); c.alusrca = 1'b1; c.alusrcb = 2'b10;
        push(0, 0, 0, op, c, 0);
        if (op == OP_LW) begin
          c = st(3); c.memread = 1'b1; c.iord = 1'b1;
          repeat (mstall) push(0, 0, 0, op, c, 0);
          push(0, 1, 0, op, c, 0);
          c = st(4); c.regwrite = 1'b1; c.memtoreg = 2'b01; c.instr_done = 1'b1;
          push(0, 0, 0, op, c, lat);
        end else begin
          c = st(5); c.memwrite = 1'b1; c.iord = 1'b1;
          repeat (mstall) push(0, 0, 0, op, c, 0);
          c.instr_done = 1'b1;
          push(0, 1, 0, op, c, lat);
        end
      end
      OP_R: begin
        c = st(6); c.alusrca = 1'b1; c.aluop = 2'b10;
        push(0, 0, 0, op, c, 0);
        c = st(7); c.regwrite = 1'b1; c.regdest = 2'b01; c.instr_done = 1'b1;
        push(0, 0, 0, op, c, lat);
      end
      OP_BEQ: begin
        c = st(8); c.alusrca = 1'b1; c.aluop = 2'b01; c.pcwritecond = 1'b1;
        c.pcsource = 2'b01; c.instr_done = 1'b1;
        push(0, 1, 0, op, c, lat);
      end
      OP_ORI: begin
        c = st(9); c.alusrca = 1'b1; c.alusrcb = 2'b10; c.zeroext = 1'b1; c.aluop = 2'b11;
        push(0, 1, 0, op, c, 0);
        c = st(10); c.regwrite = 1'b1; c.instr_done = 1'b1;
        push(0, 0, 0, op, c, lat);
      end
      OP_JRSAL: begin
        c = st(11); c.pcwrite = 1'b1; c.pcsource = 2'b10; c.regwrite = 1'b1;
        c.regdest = 2'b10; c.memtoreg = 2'b10; c.instr_done = 1'b1;
        push(0, 0, 0, op, c, lat);
      end
      default: begin // baln
        c = st(12); c.instr_done = 1'b1;
        if (nf) begin
          c.pcwrite = 1'b1; c.pcsource = 2'b01; c.regwrite = 1'b1;
          c.regdest = 2'b10; c.memtoreg = 2'b10;
        end
        push(0, 0, nf, op, c, lat);
      end
    endcase
  endtask

  // Single compare process, sampled mid-cycle on the falling edge.
  cyc_t ck;
  cw_t  act;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      ck  = exp_q.pop_front();
      act = {bus.pcwrite, bus.pcwritecond, bus.iord, bus.irwrite, bus.memread,
             bus.memwrite, bus.regwrite, bus.alusrca, bus.zeroext, bus.alusrcb,
             bus.aluop, bus.pcsource, bus.regdest, bus.memtoreg, bus.state,
             bus.instr_done, bus.illegal_op};
      total++;
      if (act !== ck.exp) begin
        bad++;
        $display("FAIL ctlword cyc=%0d op=%b rst=%b got=%h want=%h (state got %0d want %0d)",
                 cyc, ck.op, ck.rst, act, ck.exp, act.state, ck.exp.state);
      end
      if (act.instr_done === 1'b1) done_cnt++;
      if (act.illegal_op === 1'b1) ill_cnt++;
      if (act.memwrite === 1'b1)   mw_cnt++;
      if (act.instr_done === 1'b1 && ck.lat != 0) begin
        total++;
        if (lat_cnt + 1 != ck.lat) begin
          bad++;
          $display("FAIL latency op=%b got=%0d want=%0d", ck.op, lat_cnt + 1, ck.lat);
        end
      end
      if (ck.rst || act.instr_done === 1'b1 || act.illegal_op === 1'b1) lat_cnt = 0;
      else lat_cnt++;
      cyc++;
    end
  end

  initial begin
    bus.opcode = 6'b0; bus.mem_ready = 1'b0; bus.n_flag = 1'b0;

    push(1, 0, 0, 6'b0, '0, 0);
    push(1, 1, 1, 6'b0, '0, 0);
    run(OP_LW,    0, 0, 0, 5);
    run(OP_SW,    0, 3, 0, 7);
    run(OP_R,     0, 0, 0, 4);
    run(OP_ORI,   0, 0, 0, 4);
    run(OP_BEQ,   0, 0, 0, 3);
    run(OP_JRSAL, 0, 0, 0, 3);
    run(OP_BALN,  0, 0, 0, 3);
    run(OP_BALN,  0, 0, 1, 3);
    run(6'b111111, 0, 0, 0, 0);
    run(OP_LW,    2, 1, 0, 8);
    run(6'b000010, 1, 0, 0, 0);
    // lw abandoned by reset while in MEMRD with mem_ready high
    begin
      cw_t c;
      do_fetch(OP_LW, 0);
      c = st(1); c.alusrcb = 2'b11; push(0, 0, 0, OP_LW, c, 0);
      c = st(2); c.alusrca = 1'b1; c.alusrcb = 2'b10; push(0, 0, 0, OP_LW, c, 0);
      push(1, 1, 0, OP_LW, '0, 0);
    end
    run(OP_R,     0, 0, 0, 4);

    while (stim_q.size() != 0) begin
      cyc_t c;
      c = stim_q.pop_front();
      @(posedge clk); #1;
      reset = c.rst; bus.mem_ready = c.rdy; bus.n_flag = c.nf; bus.opcode = c.op;
      exp_q.push_back(c);
    end
    @(negedge clk); @(negedge clk);

    // Hand totals: 10 completed instructions, 2 illegal opcodes,
    // 4 memwrite cycles from the stalled sw.
    total++;
    if (done_cnt != 10) begin bad++; $display("FAIL done_count got=%0d want=10", done_cnt); end
    total++;
    if (ill_cnt != 2) begin bad++; $display("FAIL illegal_count got=%0d want=2", ill_cnt); end
    total++;
    if (mw_cnt != 4) begin bad++; $display("FAIL memwrite_cycles got=%0d want=4", mw_cnt); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
